newton_raphson_iter: RTL

Multi-cycle, parametrised Newton-Raphson reciprocal engine for the PPU divider path. It refines a reciprocal seed over `N_ITER` iterations, x(k+1) = x(k)·(2 − d·x(k)), using one shared multiplier. It has valid/ready handshakes on both sides and an optional internal seed generator. It supersedes the single-pass combinational NR stage and sits between mantissa extraction and the final quotient multiply.

---
 rtl/ppu_pkg.sv | 34 +++
 rtl/nr_mul.sv | 14 +
 rtl/newton_raphson_iter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - PPU divider shared types and fixed-point constants
// NR_SEED_GEN_EN adds the SEED state and the seed constants.
package ppu_pkg;

  localparam int MS = 8;

  typedef enum logic [2:0] {
    NR_IDLE   = 3'd0,
`ifdef NR_SEED_GEN_EN
    NR_SEED   = 3'd1,
`endif
    NR_MUL_DX = 3'd2,
    NR_MUL_XE = 3'd3,
    NR_DONE   = 3'd4
  } nr_state_t;

  // 2.0 in Q2.(w-2), which is the same bit pattern as 1 << (w-1)
  function automatic logic [63:0] fx_two(input int w);
    return 64'd1 << (w - 1);
  endfunction

`ifdef NR_SEED_GEN_EN
  // 48/17 in Q2.(w-2), truncated
  function automatic logic [63:0] nr_c1(input int w);
    return (64'd48 << (w - 2)) / 64'd17;
  endfunction

  // 32/17 in Q1.(w-1), truncated
  function automatic logic [63:0] nr_c2(input int w);
    return (64'd32 << (w - 1)) / 64'd17;
  endfunction
`endif

endpackage

// File: rtl/nr_mul.sv
// rtl/nr_mul.sv - unregistered unsigned multiplier shared by the NR engine
// Kept as its own block so a DSP or pipelined multiplier can replace it.
module nr_mul #(
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] p
);

  assign p = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};

endmodule

// File: rtl/newton_raphson_iter.sv
// rtl/newton_raphson_iter.sv - multi-cycle Newton-Raphson reciprocal engine
// NR_SEED_GEN_EN selects the internal linear seed generator instead of x0_i.
module newton_raphson_iter #(
  parameter int MS     = ppu_pkg::MS,
  parameter int W      = 2 * MS,
  parameter int N_ITER = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [MS-1:0] d_i,
  input  logic [W-1:0]  x0_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  x_o
);
  import ppu_pkg::*;

  localparam int CW = 3;
  localparam logic [W-1:0]  FX_2  = W'(fx_two(W));
  localparam logic [CW-1:0] N_END = CW'(N_ITER);

  nr_state_t       state;
  logic [MS-1:0]   d_r;
  logic [W-1:0]    x_r;
  logic [W-1:0]    e_r;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    p_dx;
  logic [W-1:0]    e_dx;
  logic [W-1:0]    x_xe;
  logic [CW-1:0]   cnt_inc;
  logic            unused_bits;

`ifdef NR_SEED_GEN_EN
  localparam logic [W-1:0] C1 = W'(nr_c1(W));
  localparam logic [W-1:0] C2 = W'(nr_c2(W));

  logic [2*W-1:0] seed_full;
  logic [W-1:0]   x_seed;

  // C1 is doubled to move it from Q2.(W-2) onto the Q1.(W-1) grid of x
  assign seed_full   = {{(W-1){1'b0}}, C1, 1'b0} - (prod >> (MS - 1));
  assign x_seed      = seed_full[W-1:0];
  assign unused_bits = ^{x0_i, seed_full[2*W-1:W]};
`else
  assign unused_bits = ^prod[2*W-1 -: 2];
`endif

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
`ifdef NR_SEED_GEN_EN
      NR_SEED: begin
        mul_a = W'(d_r);
        mul_b = C2;
      end
`endif
      NR_MUL_DX: begin
        mul_a = W'(d_r);
        mul_b = x_r;
      end
      NR_MUL_XE: begin
        mul_a = x_r;
        mul_b = e_r;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  nr_mul #(
    .A_W(W),
    .B_W(W)
  ) u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(prod)
  );

  // Q1.(MS-1) * Q1.(W-1) is realigned to Q2.(W-2) by dropping MS bits
  assign p_dx    = W'(prod >> MS);
  assign e_dx    = FX_2 - p_dx;
  assign x_xe    = W'(prod >> (W - 2));
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= NR_IDLE;
      d_r         <= '0;
      x_r         <= '0;
      e_r         <= '0;
      cnt         <= '0;
      x_o         <= '0;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
    end else begin
      case (state)
        NR_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            d_r        <= d_i;
            cnt        <= '0;
            in_ready_o <= 1'b0;
`ifdef NR_SEED_GEN_EN
            state      <= NR_SEED;
`else
            x_r        <= x0_i;
            state      <= NR_MUL_DX;
`endif
          end
        end
`ifdef NR_SEED_GEN_EN
        NR_SEED: begin
          x_r   <= x_seed;
          state <= NR_MUL_DX;
        end
`endif
        NR_MUL_DX: begin
          e_r   <= e_dx;
          state <= NR_MUL_XE;
        end
        NR_MUL_XE: begin
          x_r <= x_xe;
          x_o <= x_xe;
          cnt <= cnt_inc;
          if (cnt_inc == N_END) begin
            out_valid_o <= 1'b1;
            state       <= NR_DONE;
          end else begin
            state <= NR_MUL_DX;
          end
        end
        NR_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= NR_IDLE;
          end
        end
        default: begin
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          state       <= NR_IDLE;
        end
      endcase
    end
  end

endmodule
